// File: rtl/esp_resp_parser_if.sv
// esp_resp_parser_if: PMOD UART rx, monitor UART tx and sequencer handshake bundle
interface esp_resp_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       arm;
   logic       busy;
   logic       resp_done;
   logic [1:0] resp_code;
   modport master (
      output rx_data, rx_valid, tx_ready, arm,
      input  rx_ready, tx_data, tx_valid, busy, resp_done, resp_code
   );
   modport slave (
      input  rx_data, rx_valid, tx_ready, arm,
      output rx_ready, tx_data, tx_valid, busy, resp_done, resp_code
   );
endinterface

// File: rtl/esp_resp_parser.sv
// esp_resp_parser: classifies ESP32 AT responses (OK/ERROR/timeout); echo FIFO built when ESP_RESP_ECHO_EN is defined
module esp_resp_parser #(
   parameter int TIMEOUT_CYCLES = 100000000,
   parameter int CNT_W          = 27,
   parameter int FIFO_DEPTH     = 16
) (
   input logic             clk,
   input logic             rst,
   esp_resp_parser_if.slave bus
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t           state;
   logic [CNT_W-1:0] timer;
   logic [2:0]       len;
   logic             ok_p, err_p;
   logic             rx_hs, is_cr, is_lf, ok_n, err_n, lf_ok, lf_err, tmo;
   logic [7:0]       ok_c, err_c;
   // next-prefix flags compare the incoming byte against the expected char at position len
   always_comb begin
      rx_hs  = bus.rx_valid && bus.rx_ready;
      is_cr  = bus.rx_data == 8'h0D;
      is_lf  = bus.rx_data == 8'h0A;
      ok_c   = (len == 3'd0) ? 8'h4F : 8'h4B;
      err_c  = (len == 3'd0) ? 8'h45 : (len == 3'd3) ? 8'h4F : 8'h52;
      ok_n   = ok_p && (len >= 3'd2 || bus.rx_data == ok_c);
      err_n  = err_p && (len >= 3'd5 || bus.rx_data == err_c);
      lf_ok  = rx_hs && is_lf && ok_p && len == 3'd2;
      lf_err = rx_hs && is_lf && err_p && len == 3'd5;
      tmo    = timer == CNT_W'(TIMEOUT_CYCLES - 1);
   end
   // line tracker: runs on every accepted byte, restarted by LF and by an accepted arm
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && bus.arm) || (rx_hs && is_lf)) begin
         len   <= 3'd0;
         ok_p  <= 1'b1;
         err_p <= 1'b1;
      end else if (rx_hs && !is_cr) begin
         len   <= (len == 3'd7) ? len : len + 3'd1;
         ok_p  <= ok_n;
         err_p <= err_n;
      end
   end
   // response FSM with timer; a line match takes priority over a coincident timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         bus.busy      <= 1'b0;
         bus.resp_done <= 1'b0;
         bus.resp_code <= 2'b00;
      end else begin
         bus.resp_done <= 1'b0;
         if (state == IDLE) begin
            if (bus.arm) begin
               state         <= WAIT;
               timer         <= '0;
               bus.busy      <= 1'b1;
               bus.resp_code <= 2'b00;
            end
         end else begin
            timer <= timer + 1'b1;
            if (lf_ok || lf_err || tmo) begin
               state         <= IDLE;
               bus.busy      <= 1'b0;
               bus.resp_done <= 1'b1;
               bus.resp_code <= lf_ok ? 2'b01 : lf_err ? 2'b10 : 2'b11;
            end
         end
      end
   end
`ifdef ESP_RESP_ECHO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          pop;
   assign pop          = bus.tx_valid && bus.tx_ready;
   assign bus.rx_ready = count != (AW+1)'(FIFO_DEPTH);
   assign bus.tx_valid = count != '0;
   assign bus.tx_data  = bus.tx_valid ? mem[rd_ptr] : 8'h00;
   // echo storage, written on every accepted rx byte
   always_ff @(posedge clk) begin
      if (rx_hs) mem[wr_ptr] <= bus.rx_data;
   end
   // first-word-fall-through pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (rx_hs) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(rx_hs) - (AW+1)'(pop);
      end
   end
`else
   logic unused_tx_ready;
   assign unused_tx_ready = bus.tx_ready;
   assign bus.rx_ready    = 1'b1;
   assign bus.tx_valid    = 1'b0;
   assign bus.tx_data     = 8'h00;
`endif
endmodule

// File: doc/esp_resp_parser.md
# esp_resp_parser

Consumes the byte stream received from the ESP32 PMOD UART and classifies each AT-command response as OK, ERROR or timeout for the command sequencer. It also forwards every received byte to the monitor UART transmitter through a small FIFO. It sits between the PMOD UART receive interface (upstream) and the command sequencer plus the monitor UART transmit interface (downstream).

## Interface
- TIMEOUT_CYCLES, 100000000, cycles allowed from arm to response (1 s at 100 MHz); must be ≥ 2
- CNT_W, 27, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES
- FIFO_DEPTH, 16, echo FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from PMOD UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- tx_data  out  8  echo byte to monitor UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  monitor transmitter accepts byte
- arm  in  1  one-cycle pulse: command fully sent, start waiting for response
- busy  out  1  high while waiting for a response
- resp_done  out  1  one-cycle pulse when a response is classified
- resp_code  out  2  00 none, 01 OK, 10 ERROR, 11 timeout; held until next accepted arm

## Operation
- FSM states: IDLE and WAIT. Reset enters IDLE.
- IDLE: arm=1 → WAIT. Timer cleared; line tracker cleared; resp_code←00.
- WAIT: arm is ignored. A match or timeout returns to IDLE with resp_done=1 and resp_code set.
- Line tracker runs in both states on every accepted byte:
  - 0x0D (CR) is ignored.
  - 0x0A (LF) terminates the line.
  - Any other byte increments len, which saturates at 7, and updates two flags: ok_p (line prefix equals "OK") and err_p (line prefix equals "ERROR").
- On LF:
  - OK when ok_p && len==2.
  - ERROR when err_p && len==5.
  - Any other line (echo, "busy p...", blank) is discarded.
  - len, ok_p and err_p are reinitialised to 0, 1 and 1.
- Classification only reports in WAIT. Lines completed in IDLE are discarded.
- Timer increments every WAIT cycle. Timeout fires when the timer reaches TIMEOUT_CYCLES−1.
- Same cycle as a match and a timeout: the match wins.
- Reset outputs: rx_ready=1 (FIFO empty), tx_valid=0, tx_data=0, busy=0, resp_done=0, resp_code=00.

## Timing
- resp_done/resp_code are registered. They assert on the cycle after the LF handshake cycle.
- Timeout resp_done asserts exactly TIMEOUT_CYCLES cycles after the arm cycle.
- busy rises on the cycle after arm. busy falls in the same cycle resp_done asserts.
- Echo FIFO behaviour:
  - Accepted byte is visible on tx_data/tx_valid the next cycle.
  - First-word-fall-through.
  - Push and pop in the same cycle are allowed when not full or empty.
- rx_ready = !full, so there is no overflow; upstream stalls when full. Push while full is impossible by construction. Pop while empty is impossible (tx_valid=0).
- tx_data/tx_valid hold stable until tx_ready.
- rst mid-WAIT: back to IDLE, no resp_done pulse, FIFO emptied, timer and line state cleared.

## Configuration
- ESP_RESP_ECHO_EN defined:
  - Echo FIFO built.
  - rx_ready = !full.
  - tx_* driven from the FIFO.
- ESP_RESP_ECHO_EN undefined:
  - No FIFO.
  - rx_ready tied 1, tx_valid tied 0, tx_data tied 0.
  - Parsing and timing are otherwise identical.

## Test plan
- Arm, then feed "AT\r\n\r\nOK\r\n" with tx_ready=1 → one resp_done, resp_code=01, one cycle after the final LF. tx stream reproduces all 10 bytes in order.
- Arm, then feed "ERROR\r\n" → resp_done with resp_code=10. Feed "OKAY\r\n" and "ERR\r\n" → no resp_done (busy stays 1).
- TIMEOUT_CYCLES=50, arm, no input → resp_done with resp_code=11 exactly 50 cycles after arm. busy=0 thereafter.
- tx_ready=0 and 20 bytes offered with FIFO_DEPTH=16 → rx_ready drops after 16 accepts. Release tx_ready → remaining 4 bytes accepted, all 20 echoed in order.
- Assert rst during WAIT after "O" received → next cycle busy=0, resp_code=00, tx_valid=0. Subsequent arm + "K\r\n" → no match.
- Build without ESP_RESP_ECHO_EN and repeat the first test → resp_code=01, rx_ready constantly 1, tx_valid constantly 0.
